caliptra_prim_onehot_check_mc: RTL and testbench

- Multi-channel, registered successor to the combinational onehot checker.
- Checks NumChan independent onehot/address/enable tuples per cycle through an optional pipeline stage.
- Latches sticky per-channel errors, first-error channel/cause and a saturating error-cycle counter.
- Sits beside mux/FSM-select logic in crypto and key-vault datapaths; err_o feeds a fatal alert.

---
 rtl/caliptra_prim_onehot_pkg.sv | 22 ++
 rtl/caliptra_prim_onehot_check_core.sv | 57 +++++
 rtl/caliptra_prim_onehot_check_mc.sv | 170 +++++++++++++++++
 tb/tb_caliptra_prim_onehot_check_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_prim_onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module  : caliptra_prim_onehot_pkg
// Brief   : Shared cause encoding for the onehot checkers.
// Revision: 1.0 - initial release
// ============================================================================
package caliptra_prim_onehot_pkg;

    // Cause bit order {addr, enable, oh0}
    typedef struct packed {
        logic addr;
        logic enable;
        logic oh0;
    } cause_t;

    localparam int unsigned c_cause_oh0    = 0;
    localparam int unsigned c_cause_enable = 1;
    localparam int unsigned c_cause_addr   = 2;
    localparam int unsigned c_cause_w      = 3;

endpackage
`default_nettype wire

// File: rtl/caliptra_prim_onehot_check_core.sv
`default_nettype none
// ============================================================================
// Module  : caliptra_prim_onehot_check_core
// Brief   : Combinational single-channel onehot/address/enable tree checker.
// Revision: 1.0 - initial release
// ============================================================================
module caliptra_prim_onehot_check_core
    import caliptra_prim_onehot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned ONEHOT_WIDTH = 2**ADDR_WIDTH,
    parameter bit          ADDR_CHECK   = 1'b1,
    parameter bit          ENABLE_CHECK = 1'b1,
    parameter bit          STRICT_CHECK = 1'b1
) (
    input  logic [ONEHOT_WIDTH-1:0] i_oh,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_en,
    output cause_t                  o_cause
);

    localparam int unsigned c_leaves = 2**ADDR_WIDTH;

    logic [c_leaves-1:0] w_pad;
    logic [c_leaves-1:0] w_or;
    logic [c_leaves-1:0] w_sel;
    logic [c_leaves-1:0] w_err;

    // Reduce pairs level by level in place; level l steers the select tree with addr[l].
    always_comb begin
        w_pad = '0;
        w_pad[ONEHOT_WIDTH-1:0] = i_oh;
        w_or  = w_pad;
        w_sel = w_pad;
        w_err = '0;
        for (int l = 0; l < int'(ADDR_WIDTH); l++) begin
            for (int j = 0; j < int'(c_leaves >> 1); j++) begin
                w_err[j] = (w_or[2*j] & w_or[2*j+1]) | w_err[2*j] | w_err[2*j+1];
                w_sel[j] = i_addr[l] ? w_sel[2*j+1] : w_sel[2*j];
                w_or[j]  = w_or[2*j] | w_or[2*j+1];
            end
        end
    end

    always_comb begin
        o_cause     = '0;
        o_cause.oh0 = w_err[0];
        if (ENABLE_CHECK) begin
            o_cause.enable = STRICT_CHECK ? (w_or[0] ^ i_en) : (~i_en & w_or[0]);
        end
        if (ADDR_CHECK) begin
            o_cause.addr = w_or[0] ^ w_sel[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/caliptra_prim_onehot_check_mc.sv
`default_nettype none
// ============================================================================
// Module  : caliptra_prim_onehot_check_mc
// Brief   : Multi-channel registered onehot checker with sticky errors,
//           first-error capture and a saturating error-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
module caliptra_prim_onehot_check_mc
    import caliptra_prim_onehot_pkg::*;
#(
    parameter int unsigned NUM_CHAN     = 4,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned ONEHOT_WIDTH = 2**ADDR_WIDTH,
    parameter bit          ADDR_CHECK   = 1'b1,
    parameter bit          ENABLE_CHECK = 1'b1,
    parameter bit          STRICT_CHECK = 1'b1,
    parameter int unsigned PIPE_STAGES  = 0,
    parameter int unsigned CNT_WIDTH    = 8,
    localparam int unsigned FIRST_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_CHAN-1:0]              valid_i,
    input  logic [NUM_CHAN*ONEHOT_WIDTH-1:0] oh_i,
    input  logic [NUM_CHAN*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_CHAN-1:0]              en_i,
    input  logic                             clr_i,
    output logic                             err_o,
    output logic [NUM_CHAN-1:0]              err_chan_o,
    output logic                             first_vld_o,
    output logic [FIRST_W-1:0]               first_chan_o,
    output logic [2:0]                       first_cause_o,
    output logic [CNT_WIDTH-1:0]             err_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    if (ADDR_CHECK && !ENABLE_CHECK) begin : g_bad_addr_check
        $error("ADDR_CHECK requires ENABLE_CHECK");
    end
    if (PIPE_STAGES > 1) begin : g_bad_pipe
        $error("PIPE_STAGES must be 0 or 1");
    end
    if (ONEHOT_WIDTH > 2**ADDR_WIDTH) begin : g_bad_width
        $error("ONEHOT_WIDTH must not exceed 2**ADDR_WIDTH");
    end

    cause_t [NUM_CHAN-1:0]          w_cause_raw;
    logic   [NUM_CHAN-1:0][2:0]     w_cause_vld;
    logic   [NUM_CHAN-1:0][2:0]     w_cause;
    logic   [NUM_CHAN-1:0]          w_hit;
    logic                           w_any_hit;
    logic   [FIRST_W-1:0]           w_first_idx;
    logic   [2:0]                   w_first_cause;
    logic   [NUM_CHAN-1:0]          w_err_chan_d;

    logic   [NUM_CHAN-1:0]          r_err_chan;
    logic                           r_err;
    logic                           r_first_vld;
    logic   [FIRST_W-1:0]           r_first_chan;
    logic   [2:0]                   r_first_cause;
    logic   [CNT_WIDTH-1:0]         r_err_cnt;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        caliptra_prim_onehot_check_core #(
            .ADDR_WIDTH   (ADDR_WIDTH),
            .ONEHOT_WIDTH (ONEHOT_WIDTH),
            .ADDR_CHECK   (ADDR_CHECK),
            .ENABLE_CHECK (ENABLE_CHECK),
            .STRICT_CHECK (STRICT_CHECK)
        ) u_core (
            .i_oh    (oh_i[c*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
            .i_addr  (addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_en    (en_i[c]),
            .o_cause (w_cause_raw[c])
        );

        assign w_cause_vld[c] = w_cause_raw[c] & {3{valid_i[c]}};

        if (PIPE_STAGES == 0) begin : g_chk_direct
            a_raw_to_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
                w_cause_vld[c] != 3'b000 |=> r_err_chan[c]);
        end
    end

    if (PIPE_STAGES == 1) begin : g_pipe
        logic [NUM_CHAN-1:0][2:0] r_cause_pipe;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cause_pipe <= '0;
            end else begin
                r_cause_pipe <= w_cause_vld;
            end
        end

        assign w_cause = r_cause_pipe;

        for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chk_pipe
            a_raw_to_pipe: assert property (@(posedge clk_i) disable iff (!rst_ni)
                w_cause_vld[c] != 3'b000 |=> r_cause_pipe[c] != 3'b000);
            a_pipe_to_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
                r_cause_pipe[c] != 3'b000 |=> r_err_chan[c]);
        end
    end else begin : g_no_pipe
        assign w_cause = w_cause_vld;
    end

    // Descending scan leaves the lowest hitting channel as the winner.
    always_comb begin
        w_hit         = '0;
        w_first_idx   = '0;
        w_first_cause = '0;
        for (int c = int'(NUM_CHAN) - 1; c >= 0; c--) begin
            w_hit[c] = |w_cause[c];
            if (w_hit[c]) begin
                w_first_idx   = FIRST_W'(c);
                w_first_cause = w_cause[c];
            end
        end
    end

    assign w_any_hit    = |w_hit;
    assign w_err_chan_d = (r_err_chan & ~{NUM_CHAN{clr_i}}) | w_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_chan    <= '0;
            r_err         <= 1'b0;
            r_first_vld   <= 1'b0;
            r_first_chan  <= '0;
            r_first_cause <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_err_chan <= w_err_chan_d;
            r_err      <= |w_err_chan_d;

            if ((!r_first_vld || clr_i) && w_any_hit) begin
                r_first_vld   <= 1'b1;
                r_first_chan  <= w_first_idx;
                r_first_cause <= w_first_cause;
            end else if (clr_i) begin
                r_first_vld   <= 1'b0;
                r_first_chan  <= '0;
                r_first_cause <= '0;
            end

            if (clr_i) begin
                r_err_cnt <= w_any_hit ? CNT_WIDTH'(1) : '0;
            end else if (w_any_hit && r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    a_sticky_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !clr_i |=> (r_err_chan & $past(r_err_chan)) == $past(r_err_chan));

    a_cnt_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_err_cnt == c_cnt_max && !clr_i) |=> r_err_cnt == c_cnt_max);

    assign err_o         = r_err;
    assign err_chan_o    = r_err_chan;
    assign first_vld_o   = r_first_vld;
    assign first_chan_o  = r_first_chan;
    assign first_cause_o = r_first_cause;
    assign err_cnt_o     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_caliptra_prim_onehot_check_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_caliptra_prim_onehot_check_mc
// Brief   : Directed self-checking bench for the multi-channel onehot checker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_caliptra_prim_onehot_check_mc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] oh;
    logic [11:0] addr;
    logic [3:0]  en;
    logic        clr;

    // a: strict, no pipe, 4-bit counter; b: non-strict; c: strict, one pipe stage
    logic       a_err, b_err, c_err;
    logic [3:0] a_chan, b_chan, c_chan;
    logic       a_fv, b_fv, c_fv;
    logic [1:0] a_fc, b_fc, c_fc;
    logic [2:0] a_cause, b_cause, c_cause;
    logic [3:0] a_cnt, b_cnt;
    logic [7:0] c_cnt;

    int total = 0;
    int bad   = 0;

    caliptra_prim_onehot_check_mc #(
        .NUM_CHAN(4), .ADDR_WIDTH(3), .ONEHOT_WIDTH(8), .ADDR_CHECK(1'b1),
        .ENABLE_CHECK(1'b1), .STRICT_CHECK(1'b1), .PIPE_STAGES(0), .CNT_WIDTH(4)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .oh_i(oh), .addr_i(addr),
        .en_i(en), .clr_i(clr), .err_o(a_err), .err_chan_o(a_chan),
        .first_vld_o(a_fv), .first_chan_o(a_fc), .first_cause_o(a_cause),
        .err_cnt_o(a_cnt)
    );

    caliptra_prim_onehot_check_mc #(
        .NUM_CHAN(4), .ADDR_WIDTH(3), .ONEHOT_WIDTH(8), .ADDR_CHECK(1'b1),
        .ENABLE_CHECK(1'b1), .STRICT_CHECK(1'b0), .PIPE_STAGES(0), .CNT_WIDTH(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .oh_i(oh), .addr_i(addr),
        .en_i(en), .clr_i(clr), .err_o(b_err), .err_chan_o(b_chan),
        .first_vld_o(b_fv), .first_chan_o(b_fc), .first_cause_o(b_cause),
        .err_cnt_o(b_cnt)
    );

    caliptra_prim_onehot_check_mc #(
        .NUM_CHAN(4), .ADDR_WIDTH(3), .ONEHOT_WIDTH(8), .ADDR_CHECK(1'b1),
        .ENABLE_CHECK(1'b1), .STRICT_CHECK(1'b1), .PIPE_STAGES(1), .CNT_WIDTH(8)
    ) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .oh_i(oh), .addr_i(addr),
        .en_i(en), .clr_i(clr), .err_o(c_err), .err_chan_o(c_chan),
        .first_vld_o(c_fv), .first_chan_o(c_fc), .first_cause_o(c_cause),
        .err_cnt_o(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [7:0] o, input logic [2:0] a, input logic e);
        oh[c*8 +: 8]   = o;
        addr[c*3 +: 3] = a;
        en[c]          = e;
    endtask

    task automatic clean();
        for (int c = 0; c < 4; c++) set_ch(c, 8'h04, 3'd2, 1'b1);
        valid = 4'hF;
    endtask

    // Two clear cycles so the pipelined instance is flushed as well.
    task automatic clear_all();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        oh    = '0;
        addr  = '0;
        en    = '0;
        clean();
        tick();
        tick();
        chk("rst_err_o", 32'(a_err), 32'h0);
        chk("rst_err_chan", 32'(a_chan), 32'h0);
        chk("rst_first_vld", 32'(a_fv), 32'h0);
        chk("rst_cnt", 32'(a_cnt), 32'h0);
        rst_n = 1'b1;

        // Legal traffic on every channel
        repeat (10) tick();
        chk("clean_err_o", 32'(a_err), 32'h0);
        chk("clean_cnt", 32'(a_cnt), 32'h0);
        chk("clean_first_vld", 32'(a_fv), 32'h0);
        chk("clean_pipe_err_o", 32'(c_err), 32'h0);

        // Channel 2 carries two set bits for one cycle
        set_ch(2, 8'h0C, 3'd2, 1'b1);
        tick();
        clean();
        chk("oh0_err_chan", 32'(a_chan), 32'h4);
        chk("oh0_err_o", 32'(a_err), 32'h1);
        chk("oh0_first_cause", 32'(a_cause), 32'h1);
        chk("oh0_first_chan", 32'(a_fc), 32'h2);
        chk("oh0_cnt", 32'(a_cnt), 32'h1);
        chk("oh0_pipe_not_yet", 32'(c_chan), 32'h0);
        tick();
        chk("oh0_pipe_err_chan", 32'(c_chan), 32'h4);
        chk("oh0_pipe_err_o", 32'(c_err), 32'h1);
        repeat (20) tick();
        chk("oh0_hold_chan", 32'(a_chan), 32'h4);
        chk("oh0_hold_cnt", 32'(a_cnt), 32'h1);
        chk("oh0_hold_first_vld", 32'(a_fv), 32'h1);

        clear_all();
        chk("clr_err_chan", 32'(a_chan), 32'h0);
        chk("clr_err_o", 32'(a_err), 32'h0);
        chk("clr_first_vld", 32'(a_fv), 32'h0);
        chk("clr_cnt", 32'(a_cnt), 32'h0);

        // Simultaneous enable error on ch3 and address error on ch1
        set_ch(3, 8'h01, 3'd2, 1'b0);
        set_ch(1, 8'h01, 3'd3, 1'b1);
        tick();
        clean();
        chk("multi_first_chan", 32'(a_fc), 32'h1);
        chk("multi_first_cause", 32'(a_cause), 32'h4);
        chk("multi_err_chan", 32'(a_chan), 32'hA);
        chk("multi_cnt", 32'(a_cnt), 32'h1);
        chk("multi_nonstrict_chan", 32'(b_chan), 32'hA);
        clear_all();

        // Bad sample masked by valid
        set_ch(0, 8'h03, 3'd2, 1'b1);
        valid = 4'hE;
        tick();
        clean();
        chk("masked_err_chan", 32'(a_chan), 32'h0);
        chk("masked_err_o", 32'(a_err), 32'h0);
        tick();
        chk("masked_pipe_chan", 32'(c_chan), 32'h0);

        // Enabled with an empty onehot vector
        set_ch(0, 8'h00, 3'd2, 1'b1);
        tick();
        clean();
        chk("empty_strict_chan", 32'(a_chan), 32'h1);
        chk("empty_strict_cause", 32'(a_cause), 32'h2);
        chk("empty_nonstrict_chan", 32'(b_chan), 32'h0);
        chk("empty_nonstrict_cnt", 32'(b_cnt), 32'h0);
        clear_all();

        // Counter saturation, then clear while channel 0 still errs
        set_ch(0, 8'h03, 3'd2, 1'b1);
        repeat (20) tick();
        chk("sat_cnt", 32'(a_cnt), 32'hF);
        chk("sat_pipe_cnt", 32'(c_cnt), 32'd19);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrhit_cnt", 32'(a_cnt), 32'h1);
        chk("clrhit_err_chan", 32'(a_chan), 32'h1);
        chk("clrhit_first_chan", 32'(a_fc), 32'h0);
        chk("clrhit_first_vld", 32'(a_fv), 32'h1);
        chk("clrhit_first_cause", 32'(a_cause), 32'h5);
        chk("clrhit_pipe_cnt", 32'(c_cnt), 32'h1);
        clean();
        tick();
        clear_all();

        // Reset while an error sits in the pipeline register
        set_ch(1, 8'h0C, 3'd2, 1'b1);
        tick();
        clean();
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_chan", 32'(a_chan), 32'h0);
        chk("async_rst_c_err_o", 32'(c_err), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("inflight_c_chan", 32'(c_chan), 32'h0);
        chk("inflight_c_err_o", 32'(c_err), 32'h0);
        chk("inflight_c_cnt", 32'(c_cnt), 32'h0);
        chk("inflight_c_first_vld", 32'(c_fv), 32'h0);
        chk("inflight_c_first_chan", 32'(c_fc), 32'h0);
        chk("inflight_c_first_cause", 32'(c_cause), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
